// File: rtl/uart_pkg.sv
// Shared UART types and encodings for the uart_tx / uart_rx pair.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP0,
        ST_STOP1
    } tx_state_t;

    localparam int unsigned DATA_BITS_BASE = 5;

    localparam logic PARITY_NONE = 1'b0;
    localparam logic PARITY_EVEN = 1'b1;

    localparam logic STOP_ONE = 1'b0;
    localparam logic STOP_TWO = 1'b1;

    // Index of the last data bit (N-1) for a data_bits code.
    function automatic logic [2:0] last_bit_idx(input logic [1:0] data_bits);
        return 3'(DATA_BITS_BASE - 1) + {1'b0, data_bits};
    endfunction

    // Left-align the active width so bit[N-1] sits in bit 7.
    function automatic logic [7:0] align_msb(
        input logic [7:0] d,
        input logic [1:0] data_bits
    );
        return d << (2'd3 - data_bits);
    endfunction

endpackage

// File: rtl/sync_fifo_fwft_with_clear.sv
// Synchronous first-word-fall-through FIFO with a synchronous flush.
module sync_fifo_fwft_with_clear #(
    parameter int DATA_WIDTH            = 8,
    parameter int DEPTH                 = 16,
    parameter int EXTRA_OUTPUT_REGISTER = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_clear,
    input  logic                  i_wr_en,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]           r_wr_ptr;
    logic [AW:0]           r_rd_ptr;
    logic [AW:0]           w_rd_nxt;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    // A push into a full FIFO is accepted when the head leaves this cycle.
    assign w_push = i_wr_en && (!w_full || i_rd_en) && !i_clear;
    assign w_pop  = i_rd_en && !w_empty && !i_clear;

    assign w_rd_nxt = r_rd_ptr + {{AW{1'b0}}, w_pop};

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            r_rd_ptr <= w_rd_nxt;
        end
    end

    generate
        if (EXTRA_OUTPUT_REGISTER == 0) begin : g_comb_out
            assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];
        end else begin : g_reg_out
            logic [DATA_WIDTH-1:0] r_head;
            logic [DATA_WIDTH-1:0] w_head_nxt;

            // Prefetch the next head, bypassing a write into that slot.
            assign w_head_nxt =
                (w_push && (r_wr_ptr[AW-1:0] == w_rd_nxt[AW-1:0])) ?
                i_wr_data : r_mem[w_rd_nxt[AW-1:0]];

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_head <= '0;
                end else begin
                    r_head <= w_head_nxt;
                end
            end

            assign o_rd_data = r_head;
        end
    endgenerate

    assign o_full  = w_full;
    assign o_empty = w_empty;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: TX FIFO plus frame serialiser driven by baud strobes.
// Optional UART_TX_CTS_EN gates frame start on synchronised i_cts_n.
module uart_tx
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_parity,
    input  logic [1:0] i_data_bits,
    input  logic       i_stop_bits,
    input  logic       i_fifo_clear,
    input  logic       i_fifo_wr_en,
    input  logic [7:0] i_fifo_wr_data,
    output logic       o_fifo_full,
    output logic       o_fifo_empty,
    input  logic       i_tx_strb,
    output logic       o_tx_strb_en,
    input  logic       i_cts_n,
    output logic       o_uart_tx,
    output logic       o_busy,
    output logic       o_overflow_error
);

    logic       w_fifo_rd_en;
    logic [7:0] w_fifo_rd_data;
    logic       w_fifo_full;
    logic       w_fifo_empty;
    logic       w_cts_ok;

    tx_state_t  r_state;
    logic [7:0] r_shift;
    logic [2:0] r_bit_cnt;
    logic [2:0] r_last_bit;
    logic       r_par;
    logic       r_par_en;
    logic       r_stop2;
    logic       r_tx;
    logic       r_strb_en;
    logic       r_busy;
    logic       r_ovf;

    sync_fifo_fwft_with_clear #(
        .DATA_WIDTH            (8),
        .DEPTH                 (FIFO_DEPTH),
        .EXTRA_OUTPUT_REGISTER (0)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (i_fifo_clear),
        .i_wr_en   (i_fifo_wr_en),
        .i_wr_data (i_fifo_wr_data),
        .i_rd_en   (w_fifo_rd_en),
        .o_rd_data (w_fifo_rd_data),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty)
    );

`ifdef UART_TX_CTS_EN
    (* ASYNC_REG = "TRUE" *) logic r_cts_meta;
    (* ASYNC_REG = "TRUE" *) logic r_cts_sync;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cts_meta <= 1'b1;
            r_cts_sync <= 1'b1;
        end else begin
            r_cts_meta <= i_cts_n;
            r_cts_sync <= r_cts_meta;
        end
    end

    assign w_cts_ok = ~r_cts_sync;
`else
    logic w_unused_cts;
    assign w_unused_cts = i_cts_n;
    assign w_cts_ok     = 1'b1;
`endif

    assign w_fifo_rd_en = (r_state == ST_IDLE) && !w_fifo_empty && w_cts_ok;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_last_bit <= '0;
            r_par      <= 1'b0;
            r_par_en   <= PARITY_NONE;
            r_stop2    <= STOP_ONE;
            r_tx       <= 1'b1;
            r_strb_en  <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_fifo_rd_en) begin
                        r_shift    <= align_msb(w_fifo_rd_data, i_data_bits);
                        r_last_bit <= last_bit_idx(i_data_bits);
                        r_par_en   <= i_parity;
                        r_stop2    <= i_stop_bits;
                        r_bit_cnt  <= '0;
                        r_par      <= 1'b0;
                        r_tx       <= 1'b0;
                        r_strb_en  <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= ST_START;
                    end
                end
                ST_START: begin
                    if (i_tx_strb) begin
                        r_tx    <= r_shift[7];
                        r_par   <= r_par ^ r_shift[7];
                        r_shift <= {r_shift[6:0], 1'b0};
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (i_tx_strb) begin
                        if (r_bit_cnt == r_last_bit) begin
                            if (r_par_en == PARITY_EVEN) begin
                                r_tx    <= r_par;
                                r_state <= ST_PARITY;
                            end else begin
                                r_tx    <= 1'b1;
                                r_state <= ST_STOP0;
                            end
                        end else begin
                            r_tx      <= r_shift[7];
                            r_par     <= r_par ^ r_shift[7];
                            r_shift   <= {r_shift[6:0], 1'b0};
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (i_tx_strb) begin
                        r_tx    <= 1'b1;
                        r_state <= ST_STOP0;
                    end
                end
                ST_STOP0: begin
                    if (i_tx_strb) begin
                        if (r_stop2 == STOP_TWO) begin
                            r_state <= ST_STOP1;
                        end else begin
                            r_tx      <= 1'b1;
                            r_strb_en <= 1'b0;
                            r_busy    <= 1'b0;
                            r_state   <= ST_IDLE;
                        end
                    end
                end
                ST_STOP1: begin
                    if (i_tx_strb) begin
                        r_tx      <= 1'b1;
                        r_strb_en <= 1'b0;
                        r_busy    <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    r_tx      <= 1'b1;
                    r_strb_en <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    // A write into a full FIFO is dropped unless the head pops that cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else begin
            r_ovf <= i_fifo_wr_en && w_fifo_full && !w_fifo_rd_en;
        end
    end

    assign o_uart_tx        = r_tx;
    assign o_tx_strb_en     = r_strb_en;
    assign o_busy           = r_busy;
    assign o_overflow_error = r_ovf;
    assign o_fifo_full      = w_fifo_full;
    assign o_fifo_empty     = w_fifo_empty;

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter; the TX-side counterpart of the block's uart_rx sibling.
- CPU-side writes bytes into an internal FWFT FIFO.
- A frame state machine serialises each byte on o_uart_tx using the runtime frame configuration.
- Bit timing comes from the shared baud strobe generator via a request/strobe pair.

Parameters:
FIFO_DEPTH, 16, TX FIFO depth in bytes (power of two, >=2)

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
i_parity  in  1  1 = append even parity bit
i_data_bits  in  2  data bits per frame = 5 + i_data_bits (5..8)
i_stop_bits  in  1  0 = one stop bit, 1 = two stop bits
i_fifo_clear  in  1  flush TX FIFO
i_fifo_wr_en  in  1  push i_fifo_wr_data
i_fifo_wr_data  in  8  byte to send; unused upper bits ignored for <8-bit frames
o_fifo_full  out  1  TX FIFO full
o_fifo_empty  out  1  TX FIFO empty
i_tx_strb  in  1  one-cycle bit-period strobe from baud generator
o_tx_strb_en  out  1  requests strobe generation while a frame is in flight
i_cts_n  in  1  clear-to-send, active-low (used only with UART_TX_CTS_EN)
o_uart_tx  out  1  serial line, idle high, registered
o_busy  out  1  frame in progress (state != IDLE)
o_overflow_error  out  1  one-cycle pulse: write while full (byte dropped)

Behaviour:
- Reset values: o_uart_tx=1, o_tx_strb_en=0, o_busy=0, o_overflow_error=0, FIFO empty, state=IDLE. Reset mid-frame aborts the frame; the line returns high at the next edge.
- States: IDLE, START, DATA, PARITY, STOP0, STOP1 (enum in package).
- IDLE:
  - Start condition: FIFO not empty (and CTS permits).
  - Pulse FIFO rd_en for 1 cycle and capture the FWFT head into the shift register.
  - Latch data_bits, parity enable and stop_bits; clear bit counter and parity accumulator.
  - Next edge: o_uart_tx=0, o_tx_strb_en=1, state=START.
- Every non-IDLE state holds o_uart_tx until an i_tx_strb cycle, then advances on that edge.
- START + strb -> DATA; drive the first data bit.
- Data order is MSB-first of the active width: bit[N-1] first, bit[0] last (N = latched width). This matches the uart_rx shift-left reassembly.
- Each DATA bit XORs into the parity accumulator.
- DATA + strb on the last bit -> PARITY if parity enabled (drive accumulator: even parity), else STOP0 (drive 1).
- PARITY + strb -> STOP0 (drive 1).
- STOP0 + strb -> STOP1 if stop_bits, else IDLE.
- STOP1 + strb -> IDLE.
- Entering IDLE: o_uart_tx=1, o_tx_strb_en=0. The earliest next frame starts 1 cycle after IDLE entry, so back-to-back frames get a one-clock idle gap only.
- Frame length in strobes: 1 + N + parity + (1 or 2).
- Config inputs are sampled only at frame start; changes mid-frame have no effect.
- i_fifo_clear flushes queued bytes only; an in-flight frame completes.
- FIFO conditions:
  - Write while full: byte dropped, o_overflow_error pulses the next cycle.
  - Simultaneous write and pop while full is legal (FIFO rule).
  - The FIFO is never read while empty by construction.
- i_tx_strb while IDLE is ignored.

Optional Feature:
UART_TX_CTS_EN
- Defined: a new frame starts from IDLE only when i_cts_n==0, sampled through a 2FF synchroniser (ASYNC_REG). Deassertion mid-frame does not abort the frame.
- Undefined: the port exists but is ignored, and no synchroniser is instantiated.

Decomposition:
- Package uart_pkg holds:
  - the tx_state_t enum;
  - the data-width base constant (5);
  - parity/stop encodings shared with uart_rx.
- Sub-module: the existing sync_fifo_fwft_with_clear (DATA_WIDTH 8, DEPTH FIFO_DEPTH, EXTRA_OUTPUT_REGISTER 0).
- All frame logic stays in uart_tx.

Test Plan:
- 8N1, write 0xA5, strobe every 16 clks -> line: 0, 1,0,1,0,0,1,0,1, 1; o_busy for 10 strobes; o_tx_strb_en drops on IDLE.
- 7E2 (i_data_bits=2, i_parity=1, i_stop_bits=1), write 0x53 -> 0, 1,0,1,0,0,1,1, parity 0, 1, 1.
- 5N1, write 0xFF -> 0, 1,1,1,1,1, 1; upper bits ignored. Loop back into uart_rx and read 0x1F.
- Write 17 bytes with depth 16 while stalled -> o_overflow_error pulses once. 16 frames are sent back-to-back with a 1-cycle gap each.
- Mid-frame: toggle i_data_bits and assert i_fifo_clear with 3 bytes queued -> current frame unchanged, no further frames. Then assert rst_n=0 mid-frame -> o_uart_tx=1 next edge.
- With UART_TX_CTS_EN: i_cts_n=1 with data queued -> no start. Release -> start bit within 4 clks. Raise mid-frame -> frame completes, next frame is held.
